// File: rtl/ctrl_signal_types.sv
// Shared control types for the counter controller and its memory updater.
//   updater_mode_t  : operation requested from the memory updater
//   updater_state_t : memory updater sequencing states
//   CNT_PER_LINE    : counter words packed into one EMIF line
//   CNT_LINE_W      : width of a word index within a line
package ctrl_signal_types;

  localparam int MC_HA_DP_ADDR_WIDTH = 27;

  typedef enum logic {
    ZERO_OUT_COUNTER   = 1'b0,
    WRITE_BACK_COUNTER = 1'b1
  } updater_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ZERO,
    ST_WB_RD,
    ST_WB_DRAIN,
    ST_WB_WR,
    ST_DONE,
    ST_RELEASE
  } updater_state_t;

  localparam int CNT_PER_LINE = 16;
  localparam int CNT_LINE_W   = $clog2(CNT_PER_LINE);

endpackage

// File: rtl/cnt_line_packer.sv
// Collects counter-buffer read returns into one EMIF line.
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   i_rden        : buffer read issued this cycle
//   i_rdata       : buffer read data, valid RD_LAT cycles after i_rden
//   o_line        : packed line, word k at bits [k*CNT_DATA_W +: CNT_DATA_W]
//   o_line_full   : high in the cycle the last word of a line lands
module cnt_line_packer
  import ctrl_signal_types::*;
#(
  parameter int CNT_DATA_W = 32,
  parameter int LINE_W     = 512,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_rden,
  input  logic [CNT_DATA_W-1:0] i_rdata,
  output logic [LINE_W-1:0]     o_line,
  output logic                  o_line_full
);

  logic [RD_LAT-1:0]     r_vld;
  logic [CNT_LINE_W-1:0] r_idx;
  logic [LINE_W-1:0]     r_line;
  logic                  w_ret;

  // Return valid follows the read enable through the buffer latency, so the
  // capture is tied to actual returns rather than to the FSM's cycle count.
  assign w_ret = r_vld[RD_LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld  <= '0;
      r_idx  <= '0;
      r_line <= '0;
    end else begin
      r_vld[0] <= i_rden;
      for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
      if (w_ret) begin
        r_line[r_idx*CNT_DATA_W +: CNT_DATA_W] <= i_rdata;
        // Wraps to 0 after the last word, ready for the next line.
        r_idx <= r_idx + CNT_LINE_W'(1);
      end
    end
  end

  assign o_line      = r_line;
  assign o_line_full = w_ret && (r_idx == CNT_LINE_W'(CNT_PER_LINE - 1));

endmodule

// File: rtl/cnt_mem_updater.sv
// Counter memory updater: clears the counter buffer or writes it back to DRAM.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   start, mode       : level request (held until done) and operation select
//   done, busy        : one-cycle completion pulse, operation in progress
//   dram_base_addr    : first EMIF line address of the write-back image
//   buf_*             : counter buffer port B (address, write, read)
//   amm_*             : EMIF Avalon-MM write channel
//
// state        | meaning
// ST_IDLE      | waiting for start; latches base address on accept
// ST_ZERO      | one zero write per cycle over the whole buffer
// ST_WB_RD     | issuing 16 reads for the current line
// ST_WB_DRAIN  | waiting for the outstanding read returns
// ST_WB_WR     | line write held on EMIF until accepted
// ST_DONE      | done pulse
// ST_RELEASE   | waiting for the controller to drop start
module cnt_mem_updater
  import ctrl_signal_types::*;
#(
  parameter int CNT_ADDR_W = 10,
  parameter int CNT_DATA_W = 32,
  parameter int LINE_W     = 512,
  parameter int RD_LAT     = 2,
  parameter int AMM_ADDR_W = MC_HA_DP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  updater_mode_t         mode,
  output logic                  done,
  output logic                  busy,
  input  logic [AMM_ADDR_W-1:0] dram_base_addr,
  output logic [CNT_ADDR_W-1:0] buf_addr,
  output logic                  buf_wren,
  output logic [CNT_DATA_W-1:0] buf_wdata,
  output logic                  buf_rden,
  input  logic [CNT_DATA_W-1:0] buf_rdata,
  output logic [AMM_ADDR_W-1:0] amm_address,
  output logic                  amm_write,
  output logic [LINE_W-1:0]     amm_writedata,
  output logic [LINE_W/8-1:0]   amm_byteenable,
  input  logic                  amm_ready
);

  localparam int LINE_CNT_W = CNT_ADDR_W - CNT_LINE_W;

  updater_state_t        r_state;
  logic [AMM_ADDR_W-1:0] r_base;
  logic [CNT_ADDR_W-1:0] r_addr;
  logic [LINE_CNT_W-1:0] r_line;
  logic                  w_line_full;
  logic [LINE_W-1:0]     w_line;

  cnt_line_packer #(
    .CNT_DATA_W (CNT_DATA_W),
    .LINE_W     (LINE_W),
    .RD_LAT     (RD_LAT)
  ) u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_rden      (buf_rden),
    .i_rdata     (buf_rdata),
    .o_line      (w_line),
    .o_line_full (w_line_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_addr  <= '0;
      r_line  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base  <= dram_base_addr;
            r_addr  <= '0;
            r_line  <= '0;
            r_state <= (mode == ZERO_OUT_COUNTER) ? ST_ZERO : ST_WB_RD;
          end
        end
        ST_ZERO: begin
          r_addr <= r_addr + CNT_ADDR_W'(1);
          if (r_addr == '1) r_state <= ST_DONE;
        end
        ST_WB_RD: begin
          // r_addr runs continuously across lines; its low bits are the word index.
          r_addr <= r_addr + CNT_ADDR_W'(1);
          if (r_addr[CNT_LINE_W-1:0] == '1) r_state <= ST_WB_DRAIN;
        end
        ST_WB_DRAIN: begin
          if (w_line_full) r_state <= ST_WB_WR;
        end
        ST_WB_WR: begin
          if (amm_ready) begin
            if (r_line == '1) begin
              r_state <= ST_DONE;
            end else begin
              r_line  <= r_line + LINE_CNT_W'(1);
              r_state <= ST_WB_RD;
            end
          end
        end
        ST_DONE:    r_state <= ST_RELEASE;
        ST_RELEASE: if (!start) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done           = (r_state == ST_DONE);
    busy           = (r_state == ST_ZERO) || (r_state == ST_WB_RD) ||
                     (r_state == ST_WB_DRAIN) || (r_state == ST_WB_WR) ||
                     (r_state == ST_DONE);
    buf_addr       = r_addr;
    buf_wren       = (r_state == ST_ZERO);
    buf_wdata      = '0;
    buf_rden       = (r_state == ST_WB_RD);
    amm_write      = (r_state == ST_WB_WR);
    amm_address    = r_base + AMM_ADDR_W'(r_line);
    amm_writedata  = w_line;
    amm_byteenable = amm_write ? '1 : '0;
  end

endmodule
